// File: rtl/ap_ctrl_profiler.sv
// ap_ctrl_profiler: observes ap_ctrl_hs / ap_ctrl_chain handshakes on NUM_CH
// HLS sub-blocks and keeps per-channel transaction, latency and stall
// statistics behind a one-cycle register-style read port.

// Per-channel tracker: handshake FSM plus the five saturating statistics.
module ap_ctrl_profiler_ch #(
  parameter int CNT_W = 32,
  parameter bit COMB  = 1'b0
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             ready_i,
  input  logic             done_i,
  input  logic             cont_i,
  output logic [1:0]       st_o,
  output logic             busy_d_o,
  output logic [CNT_W-1:0] txn_o,
  output logic [CNT_W-1:0] last_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic [CNT_W-1:0] stall_o
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_STALL = 2'd2} st_e;

  localparam logic [CNT_W-1:0] ONES = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ONES) ? v : v + CNT_W'(1);
  endfunction

  st_e              st_q, st_d;
  logic [CNT_W-1:0] lat_q, lat_d, stall_q, stall_d;
  logic [CNT_W-1:0] txn_q, last_q, min_q, max_q;
  logic             rec;
  logic [CNT_W-1:0] rec_lat;

  // Next-state and record decision; a combinational channel never leaves IDLE.
  always_comb begin
    st_d    = st_q;
    lat_d   = lat_q;
    stall_d = stall_q;
    rec     = 1'b0;
    rec_lat = '0;
    if (COMB) begin
      rec = ready_i;
    end else begin
      case (st_q)
        S_IDLE: if (start_i) begin
          lat_d = '0;
          if (done_i) begin
            rec  = 1'b1;
            st_d = cont_i ? S_IDLE : S_STALL;
          end else begin
            st_d = S_BUSY;
          end
        end
        S_BUSY: begin
          lat_d = sat_inc(lat_q);
          if (done_i) begin
            rec     = 1'b1;
            rec_lat = sat_inc(lat_q);
            st_d    = cont_i ? S_IDLE : S_STALL;
          end
        end
        S_STALL: begin
          stall_d = sat_inc(stall_q);
          if (cont_i) st_d = S_IDLE;
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  // State and statistics; clear beats everything, frozen holds everything.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      st_q    <= S_IDLE;
      lat_q   <= '0;
      stall_q <= '0;
      txn_q   <= '0;
      last_q  <= '0;
      min_q   <= ONES;
      max_q   <= '0;
    end else if (clear_i) begin
      st_q    <= S_IDLE;
      lat_q   <= '0;
      stall_q <= '0;
      txn_q   <= '0;
      last_q  <= '0;
      min_q   <= ONES;
      max_q   <= '0;
    end else if (en_i) begin
      st_q    <= st_d;
      lat_q   <= lat_d;
      stall_q <= stall_d;
      if (rec) begin
        txn_q  <= sat_inc(txn_q);
        last_q <= rec_lat;
        if (rec_lat < min_q) min_q <= rec_lat;
        if (rec_lat > max_q) max_q <= rec_lat;
      end
    end
  end

  // Busy as it will be after this edge, so the top can register it directly.
  always_comb begin
    busy_d_o = 1'b0;
    if (!clear_i) busy_d_o = en_i ? (st_d != S_IDLE) : (st_q != S_IDLE);
  end

  assign st_o    = st_q;
  assign txn_o   = txn_q;
  assign last_o  = last_q;
  assign min_o   = min_q;
  assign max_o   = max_q;
  assign stall_o = stall_q;
endmodule

// Top: channel array, freeze control, busy summary and read port.
module ap_ctrl_profiler #(
  parameter int                 NUM_CH    = 8,
  parameter int                 CNT_W     = 32,
  parameter logic [NUM_CH-1:0]  COMB_MASK = '0,
  localparam int                CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_continue,
  input  logic              clear,
  input  logic              finish,
  input  logic              rd_en,
  input  logic [CHW-1:0]    rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              any_busy,
  output logic              frozen
);
  localparam logic [CHW:0] NCH = (CHW+1)'(NUM_CH);

  logic [NUM_CH-1:0][1:0]       st;
  logic [NUM_CH-1:0]            busy_d;
  logic [NUM_CH-1:0][CNT_W-1:0] txn, last, mn, mx, stl;
  logic                         frozen_q, busy_q, rd_valid_q;
  logic [CNT_W-1:0]             rd_data_q, rd_mux;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_ctrl_profiler_ch #(.CNT_W(CNT_W), .COMB(COMB_MASK[g])) u_ch (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .clear_i  (clear),
      .en_i     (~frozen_q),
      .start_i  (ch_start[g]),
      .ready_i  (ch_ready[g]),
      .done_i   (ch_done[g]),
      .cont_i   (ch_continue[g]),
      .st_o     (st[g]),
      .busy_d_o (busy_d[g]),
      .txn_o    (txn[g]),
      .last_o   (last[g]),
      .min_o    (mn[g]),
      .max_o    (mx[g]),
      .stall_o  (stl[g])
    );
  end

  // Statistic select; sampled from current registers so reads see pre-update values.
  always_comb begin
    rd_mux = '0;
    if ({1'b0, rd_ch} < NCH) begin
      case (rd_sel)
        3'd0:    rd_mux = txn[rd_ch];
        3'd1:    rd_mux = last[rd_ch];
        3'd2:    rd_mux = mn[rd_ch];
        3'd3:    rd_mux = mx[rd_ch];
        3'd4:    rd_mux = stl[rd_ch];
        3'd5:    rd_mux = CNT_W'(st[rd_ch]);
        default: rd_mux = '0;
      endcase
    end
  end

  // Read port, busy summary and sticky freeze flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      frozen_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
      busy_q <= |busy_d;
      if (clear)       frozen_q <= 1'b0;
      else if (finish) frozen_q <= 1'b1;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign any_busy = busy_q;
  assign frozen   = frozen_q;
endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// Bench for ap_ctrl_profiler: two instances (32-bit and 8-bit counters) share
// stimulus; a timestamp-based model predicts every output each cycle, and
// directed reads pin the model against hand-computed numbers.
module tb_ap_ctrl_profiler;
  localparam int              NCH   = 5;
  localparam logic [NCH-1:0]  CMASK = 5'b01000;

  logic           ap_clk, ap_rst_n, clear, finish, rd_en;
  logic [NCH-1:0] ch_start, ch_ready, ch_done, ch_continue;
  logic [2:0]     rd_ch, rd_sel;
  logic           rv32, rv8, busy32, busy8, frz32, frz8;
  logic [31:0]    rd32;
  logic [7:0]     rd8;

  ap_ctrl_profiler #(.NUM_CH(NCH), .CNT_W(32), .COMB_MASK(CMASK)) u32 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ch_start(ch_start), .ch_ready(ch_ready),
    .ch_done(ch_done), .ch_continue(ch_continue), .clear(clear), .finish(finish),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_valid(rv32), .rd_data(rd32),
    .any_busy(busy32), .frozen(frz32));

  ap_ctrl_profiler #(.NUM_CH(NCH), .CNT_W(8), .COMB_MASK(CMASK)) u8 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ch_start(ch_start), .ch_ready(ch_ready),
    .ch_done(ch_done), .ch_continue(ch_continue), .clear(clear), .finish(finish),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_valid(rv8), .rd_data(rd8),
    .any_busy(busy8), .frozen(frz8));

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Phase: 0 idle, 1 running, 2 waiting for continue. Latency comes from
  // start/done timestamps; stall is counted per waiting cycle.
  longint     mxv [2];
  int         ph  [2][NCH];
  longint     t0  [2][NCH];
  longint     m_txn [2][NCH], m_last [2][NCH], m_min [2][NCH], m_max [2][NCH], m_stl [2][NCH];
  bit         m_vld, m_busy, m_frz;
  logic [63:0] m_dat [2];
  longint     cyc;
  logic [NCH-1:0] cmask_v;

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic m_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        ph[d][c] = 0; t0[d][c] = 0;
        m_txn[d][c] = 0; m_last[d][c] = 0; m_min[d][c] = mxv[d];
        m_max[d][c] = 0; m_stl[d][c] = 0;
      end
    m_frz = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic m_rst();
    m_clear();
    m_vld = 1'b0;
    m_dat[0] = '0;
    m_dat[1] = '0;
  endtask

  task automatic rec(input int d, input int c, input longint lat);
    m_txn[d][c] = sat(m_txn[d][c] + 1, mxv[d]);
    m_last[d][c] = lat;
    if (lat < m_min[d][c]) m_min[d][c] = lat;
    if (lat > m_max[d][c]) m_max[d][c] = lat;
  endtask

  function automatic logic [63:0] m_val(input int d, input int c, input int s);
    if (c >= NCH) return '0;
    case (s)
      0: return m_txn[d][c];
      1: return m_last[d][c];
      2: return m_min[d][c];
      3: return m_max[d][c];
      4: return m_stl[d][c];
      5: return 64'(ph[d][c]);
      default: return '0;
    endcase
  endfunction

  task automatic m_step();
    m_vld = rd_en;
    if (rd_en) for (int d = 0; d < 2; d++) m_dat[d] = m_val(d, int'(rd_ch), int'(rd_sel));
    if (clear) m_clear();
    else if (!m_frz) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NCH; c++) begin
          if (cmask_v[c]) begin
            if (ch_ready[c]) rec(d, c, 0);
          end else begin
            case (ph[d][c])
              0: if (ch_start[c]) begin
                if (ch_done[c]) begin
                  rec(d, c, 0);
                  ph[d][c] = ch_continue[c] ? 0 : 2;
                end else begin
                  t0[d][c] = cyc;
                  ph[d][c] = 1;
                end
              end
              1: if (ch_done[c]) begin
                rec(d, c, sat(cyc - t0[d][c], mxv[d]));
                ph[d][c] = ch_continue[c] ? 0 : 2;
              end
              default: begin
                m_stl[d][c] = sat(m_stl[d][c] + 1, mxv[d]);
                if (ch_continue[c]) ph[d][c] = 0;
              end
            endcase
          end
        end
      if (finish) m_frz = 1'b1;
    end
    m_busy = 1'b0;
    for (int c = 0; c < NCH; c++) if (ph[0][c] != 0) m_busy = 1'b1;
    cyc++;
  endtask

  initial begin
    mxv[0] = 64'hFFFF_FFFF;
    mxv[1] = 64'hFF;
    cmask_v = CMASK;
    cyc = 0;
    m_rst();
    forever begin
      @(posedge ap_clk or negedge ap_rst_n);
      if (!ap_rst_n) m_rst();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    #3;
    forever begin
      @(negedge ap_clk);
      chk("rd_valid32", 64'(rv32), 64'(m_vld));
      chk("rd_valid8", 64'(rv8), 64'(m_vld));
      chk("rd_data32", 64'(rd32), m_dat[0]);
      chk("rd_data8", 64'(rd8), m_dat[1]);
      chk("any_busy32", 64'(busy32), 64'(m_busy));
      chk("any_busy8", 64'(busy8), 64'(m_busy));
      chk("frozen32", 64'(frz32), 64'(m_frz));
      chk("frozen8", 64'(frz8), 64'(m_frz));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #2;
  endtask

  task automatic rd(input int ch, input int sel, input logic [63:0] e32, input logic [63:0] e8,
                    input string nm);
    rd_en = 1'b1; rd_ch = ch[2:0]; rd_sel = sel[2:0];
    tick(1);
    rd_en = 1'b0;
    chk({nm, "/32"}, 64'(rd32), e32);
    chk({nm, "/8"}, 64'(rd8), e8);
  endtask

  initial begin
    ap_rst_n = 1'b1; clear = 0; finish = 0; rd_en = 0; rd_ch = 0; rd_sel = 0;
    ch_start = '0; ch_ready = '0; ch_done = '0; ch_continue = '1;
    #1 ap_rst_n = 1'b0;
    tick(3);
    ap_rst_n = 1'b1;
    tick(1);

    // reset state
    chk("rst_busy", 64'(busy32), 64'd0);
    rd(0, 0, 0, 0, "rst_txn");
    rd(0, 1, 0, 0, "rst_last");
    rd(0, 2, 64'hFFFF_FFFF, 64'hFF, "rst_min");
    rd(0, 3, 0, 0, "rst_max");
    rd(0, 4, 0, 0, "rst_stall");
    rd(0, 5, 0, 0, "rst_state");

    // ch1: latency 7 then 3
    ch_start[1] = 1; tick(1); ch_start[1] = 0; tick(6);
    ch_done[1] = 1; tick(1); ch_done[1] = 0; tick(2);
    ch_start[1] = 1; tick(1); ch_start[1] = 0; tick(2);
    ch_done[1] = 1; tick(1); ch_done[1] = 0;
    rd(1, 0, 2, 2, "c1_txn");
    rd(1, 1, 3, 3, "c1_last");
    rd(1, 2, 3, 3, "c1_min");
    rd(1, 3, 7, 7, "c1_max");
    rd(1, 5, 0, 0, "c1_state");
    rd(1, 6, 0, 0, "c1_sel6");
    rd(1, 7, 0, 0, "c1_sel7");

    // ch2: latency 5, continue low for 4 stall cycles
    ch_start[2] = 1; tick(1); ch_start[2] = 0; tick(4);
    ch_done[2] = 1; ch_continue[2] = 0; tick(1); ch_done[2] = 0;
    rd(2, 5, 2, 2, "c2_state_stall");
    tick(2);
    chk("c2_busy_in_stall", 64'(busy32), 64'd1);
    ch_continue[2] = 1; tick(1);
    chk("c2_busy_after", 64'(busy32), 64'd0);
    rd(2, 4, 4, 4, "c2_stall");
    rd(2, 5, 0, 0, "c2_state_idle");
    rd(2, 1, 5, 5, "c2_last");

    // ch4: start and done in the same cycle
    ch_start[4] = 1; ch_done[4] = 1; tick(1); ch_start[4] = 0; ch_done[4] = 0;
    rd(4, 0, 1, 1, "c4_txn");
    rd(4, 1, 0, 0, "c4_last");
    rd(4, 2, 0, 0, "c4_min");

    // ch3 combinational: 5 ready pulses, start/done ignored
    ch_start[3] = 1; ch_done[3] = 1;
    for (int i = 0; i < 5; i++) begin
      ch_ready[3] = 1; tick(1); ch_ready[3] = 0; tick(1 + i % 2);
    end
    ch_start[3] = 0; ch_done[3] = 0;
    rd(3, 0, 5, 5, "c3_txn");
    rd(3, 1, 0, 0, "c3_last");
    rd(3, 2, 0, 0, "c3_min");
    rd(3, 3, 0, 0, "c3_max");
    rd(3, 4, 0, 0, "c3_stall");
    rd(3, 5, 0, 0, "c3_state");

    // out-of-range channel
    rd(5, 0, 0, 0, "oor5");
    rd(7, 1, 0, 0, "oor7");

    // ch0: 300-cycle transaction saturates the 8-bit instance
    ch_start[0] = 1; tick(1); ch_start[0] = 0; tick(299);
    ch_done[0] = 1; tick(1); ch_done[0] = 0;
    rd(0, 1, 300, 255, "c0_last_sat");
    rd(0, 3, 300, 255, "c0_max_sat");
    rd(0, 0, 1, 1, "c0_txn");

    // freeze mid-transaction on ch4
    ch_start[4] = 1; tick(1); ch_start[4] = 0; tick(5);
    finish = 1; tick(1); finish = 0;
    chk("frozen_set", 64'(frz32), 64'd1);
    ch_ready[3] = 1; tick(2); ch_ready[3] = 0;
    ch_done[4] = 1; tick(1); ch_done[4] = 0; tick(3);
    rd(4, 0, 1, 1, "frz_c4_txn");
    rd(4, 5, 1, 1, "frz_c4_state");
    rd(3, 0, 5, 5, "frz_c3_txn");
    chk("frozen_sticky", 64'(frz8), 64'd1);

    // clear out of frozen
    clear = 1; tick(1); clear = 0;
    chk("clr_frozen", 64'(frz32), 64'd0);
    rd(1, 0, 0, 0, "clr_c1_txn");
    rd(4, 5, 0, 0, "clr_c4_state");
    rd(0, 2, 64'hFFFF_FFFF, 64'hFF, "clr_c0_min");

    // clear in the same cycle as done on ch0, while frozen
    ch_start[0] = 1; finish = 1; tick(1); ch_start[0] = 0; finish = 0;
    chk("frz2_set", 64'(frz32), 64'd1);
    tick(2);
    ch_done[0] = 1; clear = 1; tick(1); ch_done[0] = 0; clear = 0;
    chk("clrdone_frozen", 64'(frz32), 64'd0);
    chk("clrdone_busy", 64'(busy32), 64'd0);
    rd(0, 0, 0, 0, "clrdone_txn");
    rd(0, 5, 0, 0, "clrdone_state");

    // async reset mid-transaction discards it
    ch_start[1] = 1; tick(1); ch_start[1] = 0; tick(3);
    ap_rst_n = 0; tick(1);
    chk("arst_busy", 64'(busy32), 64'd0);
    ap_rst_n = 1; tick(1);
    ch_start[1] = 1; tick(1); ch_start[1] = 0; tick(1);
    ch_done[1] = 1; tick(1); ch_done[1] = 0;
    rd(1, 0, 1, 1, "arst_txn");
    rd(1, 1, 2, 2, "arst_last");
    rd(1, 2, 2, 2, "arst_min");
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
